// File: rtl/seq_det_pkg.sv
// ============================================================================
// Module   : seq_det_pkg
// Brief    : Shared constants, config struct and width helper for the
//            parameterisable serial sequence detector.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_det_pkg;

    localparam int         c_PAT_MAX_W   = 32;
    localparam int         c_LEN_MAX_W   = 6;
    localparam logic [7:0] c_DEF_PAT     = 8'b0000_1101;
    localparam int         c_DEF_LEN     = 4;
    localparam bit         c_DEF_OVERLAP = 1'b1;

    // Sized for the largest legal pattern so one type serves every MAX_LEN.
    typedef struct packed {
        logic [c_PAT_MAX_W-1:0] pattern;
        logic [c_LEN_MAX_W-1:0] len;
        logic                   overlap;
    } seq_det_cfg_t;

    function automatic int seq_det_len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/seq_det_match_cnt.sv
// ============================================================================
// Module   : seq_det_match_cnt
// Brief    : Saturating match tally with synchronous clear.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_det_match_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             sync_reset,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (sync_reset || clear) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/seq_detector_param.sv
// ============================================================================
// Module   : seq_detector_param
// Brief    : Runtime-configurable serial pattern detector with overlap
//            control. Define SEQ_DET_COUNT_EN to add the match_count port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int                 MAX_LEN     = 8,
    parameter int                 CNT_W       = 16,
    parameter logic [MAX_LEN-1:0] DEF_PAT     = MAX_LEN'(c_DEF_PAT),
    parameter int                 DEF_LEN     = c_DEF_LEN,
    parameter bit                 DEF_OVERLAP = c_DEF_OVERLAP,
    localparam int                LEN_W       = seq_det_len_w(MAX_LEN)
) (
    input  logic               clk,
    input  logic               sync_reset,
    input  logic               in_valid,
    input  logic               in_stream,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    output logic               match,
    output logic [LEN_W-1:0]   fill
`ifdef SEQ_DET_COUNT_EN
    ,
    output logic [CNT_W-1:0]   match_count
`endif
);

    localparam int                     c_DEF_LEN_CL = (DEF_LEN > MAX_LEN) ? MAX_LEN : DEF_LEN;
    localparam logic [c_LEN_MAX_W-1:0] c_RST_LEN    = c_LEN_MAX_W'(c_DEF_LEN_CL);

    function automatic logic [c_LEN_MAX_W-1:0] clamp_len(input logic [c_LEN_MAX_W-1:0] len);
        return (int'(len) > MAX_LEN) ? c_LEN_MAX_W'(MAX_LEN) : len;
    endfunction

    seq_det_cfg_t           r_cfg;
    logic [MAX_LEN-1:0]     r_hist;
    logic [LEN_W-1:0]       r_fill;
    logic                   r_match;

    logic                   w_accept;
    logic                   w_hit;
    logic [c_PAT_MAX_W:0]   w_window;
    logic [c_PAT_MAX_W:0]   w_mask;
    logic [c_PAT_MAX_W:0]   w_pat;
    logic [c_LEN_MAX_W:0]   w_fill_inc;
    logic [c_LEN_MAX_W-1:0] w_fill_next;

    // A bit arriving alongside cfg_load belongs to the old configuration and is dropped.
    assign w_accept   = in_valid & ~cfg_load;
    assign w_window   = {c_PAT_MAX_W'(r_hist), in_stream};
    assign w_mask     = ~({(c_PAT_MAX_W + 1){1'b1}} << r_cfg.len);
    assign w_pat      = {1'b0, r_cfg.pattern};
    assign w_fill_inc = (c_LEN_MAX_W + 1)'(r_fill) + (c_LEN_MAX_W + 1)'(1);

    assign w_hit = w_accept
                && (r_cfg.len != '0)
                && (w_fill_inc >= {1'b0, r_cfg.len})
                && ((w_window & w_mask) == (w_pat & w_mask));

    always_comb begin
        w_fill_next = c_LEN_MAX_W'(r_fill);
        if (w_hit) begin
            w_fill_next = r_cfg.overlap ? r_cfg.len : '0;
        end else if (w_fill_inc <= {1'b0, r_cfg.len}) begin
            w_fill_next = w_fill_inc[c_LEN_MAX_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            r_cfg   <= '{pattern: c_PAT_MAX_W'(DEF_PAT), len: c_RST_LEN, overlap: DEF_OVERLAP};
            r_hist  <= '0;
            r_fill  <= '0;
            r_match <= 1'b0;
        end else if (cfg_load) begin
            r_cfg   <= '{pattern: c_PAT_MAX_W'(cfg_pattern),
                         len:     clamp_len(c_LEN_MAX_W'(cfg_len)),
                         overlap: cfg_overlap};
            r_hist  <= '0;
            r_fill  <= '0;
            r_match <= 1'b0;
        end else begin
            r_match <= w_hit;
            if (in_valid) begin
                r_hist <= {r_hist[MAX_LEN-2:0], in_stream};
                r_fill <= LEN_W'(w_fill_next);
            end
        end
    end

    assign match = r_match;
    assign fill  = r_fill;

`ifdef SEQ_DET_COUNT_EN
    seq_det_match_cnt #(
        .CNT_W (CNT_W)
    ) u_match_cnt (
        .clk        (clk),
        .sync_reset (sync_reset),
        .clear      (cfg_load),
        .inc        (w_hit),
        .count      (match_count)
    );
`endif

endmodule

`default_nettype wire

// File: doc/seq_detector_param.md
SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 The block SHALL expose parameter MAX_LEN, default 8: maximum pattern length in bits (2..32).
REQ-002 The block SHALL expose parameter CNT_W, default 16: match-counter width.
REQ-003 The block SHALL expose parameters DEF_PAT (MAX_LEN bits, default 8'b0000_1101), DEF_LEN (default 4) and DEF_OVERLAP (default 1): the configuration loaded at reset.
REQ-004 The block SHALL use LEN_W = $clog2(MAX_LEN+1) for all length fields.
REQ-005 The block SHALL provide port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL provide port sync_reset, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL provide port in_valid, input, 1 bit: in_stream holds a bit to be accepted this cycle.
REQ-008 The block SHALL provide port in_stream, input, 1 bit: serial data bit.
REQ-009 The block SHALL provide port cfg_load, input, 1 bit: latch cfg_pattern, cfg_len and cfg_overlap this cycle.
REQ-010 The block SHALL provide port cfg_pattern, input, MAX_LEN bits: bit [len-1] is matched first, bit [0] last.
REQ-011 The block SHALL provide port cfg_len, input, LEN_W bits: pattern length.
REQ-012 The block SHALL provide port cfg_overlap, input, 1 bit: 1 = overlapping detection, 0 = non-overlapping.
REQ-013 The block SHALL provide port match, output, 1 bit: registered single-cycle detection pulse.
REQ-014 The block SHALL provide port fill, output, LEN_W bits: count of valid history bits, saturating at the active length.
REQ-015 The block SHALL provide port match_count, output, CNT_W bits: saturating match tally; present only with SEQ_DET_COUNT_EN.

Function
REQ-016 The block SHALL hold history hist[MAX_LEN-1:0]; each accepted bit SHALL shift in as hist <= {hist[MAX_LEN-2:0], in_stream}.
REQ-017 The block SHALL detect a hit on an accepted bit when fill+1 >= len and the low len bits of {hist, in_stream} equal the low len bits of the pattern.
REQ-018 match SHALL be 1 in exactly the cycle after the edge that accepts a hit bit (one-cycle latency) and 0 otherwise.
REQ-019 Cycles with in_valid=0 SHALL leave hist and fill unchanged, and match SHALL be 0 in the following cycle.
REQ-020 On each accepted bit, fill SHALL increment, saturating at len.
REQ-021 On a hit in overlap mode, fill SHALL remain len.
REQ-022 On a hit in non-overlap mode, fill SHALL clear to 0 so no bit of a hit is reused.
REQ-023 cfg_len=0 SHALL disable detection: match stays 0 and fill stays 0.
REQ-024 cfg_len > MAX_LEN SHALL be clamped to MAX_LEN at load.
REQ-025 cfg_load SHALL latch the configuration and clear hist, fill and match_count; any bit presented with in_valid in the same cycle SHALL be discarded; match SHALL be 0 in the next cycle.
REQ-026 Configuration SHALL be static between loads; unloaded changes on the cfg_* ports SHALL have no effect.

Reset
REQ-027 sync_reset SHALL dominate cfg_load and in_valid.
REQ-028 Reset SHALL set hist=0, fill=0, match=0 and match_count=0, and load DEF_PAT, DEF_LEN (clamped) and DEF_OVERLAP.
REQ-029 A reset mid-pattern SHALL discard partial history; detection restarts from the first bit accepted after sync_reset deasserts.

Configuration
REQ-030 With SEQ_DET_COUNT_EN defined, match_count SHALL increment on each match pulse and saturate at all-ones.
REQ-031 Without SEQ_DET_COUNT_EN, the match_count port and its logic SHALL be absent, and all other behaviour SHALL be unchanged.

Structure
REQ-032 Package seq_det_pkg SHALL hold the LEN_W computation function, the default-pattern constants and a config struct (pattern, len, overlap).
REQ-033 The saturating counter SHALL be sub-module seq_det_match_cnt, instantiated only under SEQ_DET_COUNT_EN.

Verification
REQ-034 Defaults, overlap, stream 1101101 all valid -> match pulses after bits 4 and 7; match_count=2.
REQ-035 Load pattern 1101, len 4, overlap=0, same stream -> single pulse after bit 4; fill reads 3 at end.
REQ-036 Stream 11 then in_valid=0 for 5 cycles, then 01 -> one pulse after the final bit; no pulses during the gap.
REQ-037 Load len 8, pattern 8'hA5, stream 0xA5 MSB first, then sync_reset after 4 further bits of 0xA5 -> one pulse; after reset, fill=0 and 4 more bits give no pulse.
REQ-038 Load len 0 -> no pulse for any stream; cfg_len=12 with MAX_LEN=8 -> behaves as len 8.
REQ-039 With CNT_W=2 and 5 matches -> match_count saturates at 3; cfg_load with in_valid=1 -> count cleared and that bit ignored.
